corr_search_ctrl: RTL and testbench
===================================

# corr_search_ctrl

Parametrised search controller for the template-correlation path. After a frame is stored, it steps a configurable X/Y offset window. At each offset it starts one correlation, waits for the result, and keeps the best score and its coordinates. It sits between the frame-store handshake and the correlation engine, and replaces the fixed-resolution controller with a real start/done handshake, min/max selection, abort and a completion pulse.

## Interface
- COORD_W, 13, width of X/Y coordinates
- CORR_W, 16, width of correlation score (unsigned)
- X_MIN, 0, first X offset
- X_MAX, 799, last permitted X offset (inclusive)
- Y_MIN, 0, first Y offset
- Y_MAX, 599, last permitted Y offset (inclusive)
- STEP, 1, offset increment for both axes (≥1)
- MODE_MIN, 0, 0 = track largest score (correlation), 1 = track smallest (SAD)
- iCLK  in  1  control clock; all logic on rising edge
- iRST_N  in  1  asynchronous active-low reset
- iStart  in  1  one-cycle pulse: frame stored, begin scan
- iAbort  in  1  cancel scan, return to IDLE
- oX  out  COORD_W  current offset X, valid while oCorrStart high and through WAIT
- oY  out  COORD_W  current offset Y, same validity as oX
- oCorrStart  out  1  one-cycle pulse: correlate at oX/oY
- iCorrDone  in  1  one-cycle pulse: iCorrVal valid
- iCorrVal  in  CORR_W  score for current offset
- oBusy  out  1  high in any state except IDLE
- oDone  out  1  one-cycle pulse: scan complete, results valid
- oBestX, oBestY  out  COORD_W  coordinates of best score
- oBestCorr  out  CORR_W  best score
- oBestValid  out  1  high from oDone until next iStart/iAbort
- oSecondCorr  out  CORR_W  second-best score (only with CORR_PEAK2_EN)

## Operation
- States: IDLE, ISSUE, WAIT, UPDATE, DONE.
- IDLE, on iStart:
  - load X=X_MIN, Y=Y_MIN
  - clear best registers and oBestValid
  - set internal first-flag
  - go to ISSUE
- ISSUE: assert oCorrStart for one cycle, then go to WAIT.
- WAIT: hold oX/oY. On iCorrDone, capture iCorrVal and go to UPDATE.
- UPDATE: compare and advance.
  - If first-flag is set, or the score is strictly better (> for MODE_MIN=0, < for MODE_MIN=1), load oBestCorr/X/Y and clear first-flag.
  - Ties keep the earlier (raster-first) coordinate.
  - Advance: if X+STEP ≤ X_MAX, X+=STEP. Else X=X_MIN and, if Y+STEP ≤ Y_MAX, Y+=STEP. Else go to DONE.
  - Otherwise go to ISSUE.
  - Compute the bounds checks at COORD_W+1 bits so there is no wrap at the top of the range.
- DONE: pulse oDone, set oBestValid, then go to IDLE.
- iAbort has priority in every state:
  - go to IDLE next cycle
  - no oDone
  - oBestValid=0
  - best registers cleared
- Event handling:
  - iStart while oBusy is ignored.
  - iCorrDone outside WAIT is ignored.
  - iStart and iAbort together in IDLE: abort wins, stay IDLE.
- Offsets visited = ((X_MAX−X_MIN)/STEP+1)·((Y_MAX−Y_MIN)/STEP+1), in raster order.

## Timing
- Reset values:
  - state IDLE
  - oX=X_MIN, oY=Y_MIN
  - oCorrStart, oBusy, oDone, oBestValid = 0
  - oBestX, oBestY, oBestCorr, oSecondCorr = 0
- iStart at cycle t: oBusy and state ISSUE at t+1, oCorrStart high at t+1 only.
- Earliest iCorrDone accepted is t+2, the cycle after oCorrStart. The UPDATE result is visible one cycle after the iCorrDone cycle.
- Per-offset cost is 3 cycles plus the correlator latency. The next oCorrStart comes 2 cycles after iCorrDone.
- After the last UPDATE, DONE lasts 1 cycle, with oDone and oBestValid rising together. oBusy falls the cycle after oDone.
- Best outputs are registered and stable from oDone until the next iStart or iAbort.
- Asynchronous reset mid-scan forces every output to its reset value immediately.

## Configuration
- CORR_PEAK2_EN defined:
  - oSecondCorr holds the second-best score over the scan.
  - When the best is replaced, the old best moves to second.
  - Otherwise the score replaces second if strictly better than it, or if fewer than two scores have been seen.
  - Cleared on iStart and iAbort.
- Undefined: the oSecondCorr port and its logic are absent.

## Test plan
- Window X 0..3, Y 0..2, STEP 1, MODE_MIN 0, correlator model returns 10·Y+X with 3-cycle latency → 12 oCorrStart pulses in raster order, oDone once, oBestX=3, oBestY=2, oBestCorr=23.
- Same window, MODE_MIN 1, model returns 50 except 7 at (2,1) → oBestX=2, oBestY=1, oBestCorr=7.
- Constant score 5 everywhere → tie keeps first: oBestX=0, oBestY=0; with CORR_PEAK2_EN, oSecondCorr=5.
- X 0..4, Y 0..4, STEP 2 → offsets {0,2,4}², 9 pulses, oX never exceeds 4. X_MAX=8191 with COORD_W=13 → no wrap, scan terminates.
- iAbort during the 5th WAIT → IDLE next cycle, no oDone, oBestValid=0. A following iStart rescans from (X_MIN,Y_MIN).
- iRST_N low mid-scan, iStart pulsed while busy, and spurious iCorrDone in IDLE → reset values restored, the extra iStart and spurious iCorrDone have no effect, pulse count unchanged.

Source files
------------

// File: rtl/corr_search_ctrl.sv
// Offset-window search controller: steps X/Y over a raster window, runs one correlation per offset
// and keeps the best score. Optional second-best tracking is enabled with `define CORR_PEAK2_EN.
module corr_search_ctrl #(
    parameter int unsigned COORD_W  = 13,
    parameter int unsigned CORR_W   = 16,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 799,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 599,
    parameter int unsigned STEP     = 1,
    parameter int unsigned MODE_MIN = 0
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic               iAbort,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic               oCorrStart,
    input  logic               iCorrDone,
    input  logic [CORR_W-1:0]  iCorrVal,
    output logic               oBusy,
    output logic               oDone,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY,
    output logic [CORR_W-1:0]  oBestCorr,
    output logic               oBestValid
`ifdef CORR_PEAK2_EN
    ,
    output logic [CORR_W-1:0]  oSecondCorr
`endif
);

    // One extra bit so the top-of-range advance cannot wrap back into the window.
    localparam int unsigned EXT_W = COORD_W + 1;
    localparam logic [EXT_W-1:0]   X_MAX_E = EXT_W'(X_MAX);
    localparam logic [EXT_W-1:0]   Y_MAX_E = EXT_W'(Y_MAX);
    localparam logic [EXT_W-1:0]   STEP_E  = EXT_W'(STEP);
    localparam logic [COORD_W-1:0] X_MIN_C = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] Y_MIN_C = COORD_W'(Y_MIN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [COORD_W-1:0] xNext;
    logic [COORD_W-1:0] yNext;
    logic [CORR_W-1:0]  corrVal;
    logic [CORR_W-1:0]  corrValNext;
    logic               firstFlag;
    logic               firstFlagNext;
    logic [COORD_W-1:0] bestXNext;
    logic [COORD_W-1:0] bestYNext;
    logic [CORR_W-1:0]  bestCorrNext;
    logic               bestValidNext;
    logic               corrStartNext;
    logic               busyNext;
    logic               doneNext;
    logic [EXT_W-1:0]   xStep;
    logic [EXT_W-1:0]   yStep;
    logic               scoreBetter;
`ifdef CORR_PEAK2_EN
    logic [CORR_W-1:0]  secondNext;
    logic [1:0]         seenCnt;
    logic [1:0]         seenCntNext;
    logic               beatsSecond;
`endif

    assign xStep = {1'b0, oX} + STEP_E;
    assign yStep = {1'b0, oY} + STEP_E;

    // Strict comparison so ties keep the raster-first coordinate.
    always_comb begin
        if (MODE_MIN != 0) begin
            scoreBetter = (corrVal < oBestCorr);
        end else begin
            scoreBetter = (corrVal > oBestCorr);
        end
    end

`ifdef CORR_PEAK2_EN
    always_comb begin
        if (MODE_MIN != 0) begin
            beatsSecond = (corrVal < oSecondCorr);
        end else begin
            beatsSecond = (corrVal > oSecondCorr);
        end
    end
`endif

    // Next-state and next-output logic; abort overrides everything at the end.
    always_comb begin
        stateNext     = state;
        xNext         = oX;
        yNext         = oY;
        corrValNext   = corrVal;
        firstFlagNext = firstFlag;
        bestXNext     = oBestX;
        bestYNext     = oBestY;
        bestCorrNext  = oBestCorr;
        bestValidNext = oBestValid;
`ifdef CORR_PEAK2_EN
        secondNext    = oSecondCorr;
        seenCntNext   = seenCnt;
`endif

        unique case (state)
            IDLE: begin
                if (iStart) begin
                    xNext         = X_MIN_C;
                    yNext         = Y_MIN_C;
                    bestXNext     = '0;
                    bestYNext     = '0;
                    bestCorrNext  = '0;
                    bestValidNext = 1'b0;
                    firstFlagNext = 1'b1;
`ifdef CORR_PEAK2_EN
                    secondNext    = '0;
                    seenCntNext   = '0;
`endif
                    stateNext     = ISSUE;
                end
            end
            ISSUE: begin
                stateNext = WAIT;
            end
            WAIT: begin
                if (iCorrDone) begin
                    corrValNext = iCorrVal;
                    stateNext   = UPDATE;
                end
            end
            UPDATE: begin
                if (firstFlag || scoreBetter) begin
                    bestCorrNext  = corrVal;
                    bestXNext     = oX;
                    bestYNext     = oY;
                    firstFlagNext = 1'b0;
`ifdef CORR_PEAK2_EN
                    secondNext    = oBestCorr;
`endif
                end
`ifdef CORR_PEAK2_EN
                else if ((seenCnt < 2'd2) || beatsSecond) begin
                    secondNext = corrVal;
                end
                seenCntNext = (seenCnt == 2'd2) ? seenCnt : seenCnt + 2'd1;
`endif
                if (xStep <= X_MAX_E) begin
                    xNext     = COORD_W'(xStep);
                    stateNext = ISSUE;
                end else if (yStep <= Y_MAX_E) begin
                    xNext     = X_MIN_C;
                    yNext     = COORD_W'(yStep);
                    stateNext = ISSUE;
                end else begin
                    bestValidNext = 1'b1;
                    stateNext     = DONE;
                end
            end
            DONE: begin
                xNext     = X_MIN_C;
                yNext     = Y_MIN_C;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (iAbort) begin
            stateNext     = IDLE;
            xNext         = X_MIN_C;
            yNext         = Y_MIN_C;
            bestXNext     = '0;
            bestYNext     = '0;
            bestCorrNext  = '0;
            bestValidNext = 1'b0;
            firstFlagNext = 1'b0;
`ifdef CORR_PEAK2_EN
            secondNext    = '0;
            seenCntNext   = '0;
`endif
        end

        corrStartNext = (stateNext == ISSUE);
        busyNext      = (stateNext != IDLE);
        doneNext      = (stateNext == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            oX         <= X_MIN_C;
            oY         <= Y_MIN_C;
            corrVal    <= '0;
            firstFlag  <= 1'b0;
            oBestX     <= '0;
            oBestY     <= '0;
            oBestCorr  <= '0;
            oBestValid <= 1'b0;
            oCorrStart <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            state      <= stateNext;
            oX         <= xNext;
            oY         <= yNext;
            corrVal    <= corrValNext;
            firstFlag  <= firstFlagNext;
            oBestX     <= bestXNext;
            oBestY     <= bestYNext;
            oBestCorr  <= bestCorrNext;
            oBestValid <= bestValidNext;
            oCorrStart <= corrStartNext;
            oBusy      <= busyNext;
            oDone      <= doneNext;
        end
    end

`ifdef CORR_PEAK2_EN
    // Second-best score and count of scores seen (saturating at two).
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oSecondCorr <= '0;
            seenCnt     <= '0;
        end else begin
            oSecondCorr <= secondNext;
            seenCnt     <= seenCntNext;
        end
    end
`endif

endmodule

// File: tb/tb_corr_search_ctrl.sv
// Scoreboard bench for corr_search_ctrl: four parameterisations, a 3-cycle correlator model,
// and a monitor that checks every oCorrStart coordinate and every oDone result against queues.
module tb_corr_search_ctrl;

    localparam int NI = 4;

    function automatic int unsigned cfgXMin(int i);
        return (i == 3) ? 8189 : 0;
    endfunction
    function automatic int unsigned cfgXMax(int i);
        return (i == 2) ? 4 : ((i == 3) ? 8191 : 3);
    endfunction
    function automatic int unsigned cfgYMax(int i);
        return (i == 2) ? 4 : 2;
    endfunction
    function automatic int unsigned cfgStep(int i);
        return (i >= 2) ? 2 : 1;
    endfunction
    function automatic int unsigned cfgMode(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    typedef struct {
        int inst;
        int x;
        int y;
    } coord_t;

    typedef struct {
        int inst;
        int x;
        int y;
        int corr;
        int sec;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstN;
    logic [NI-1:0] start, abort, spur, mdlDone, cs, dn, busy, bv;
    logic [12:0]   ox [NI];
    logic [12:0]   oy [NI];
    logic [12:0]   bx [NI];
    logic [12:0]   by [NI];
    logic [15:0]   bc [NI];
    logic [15:0]   mdlVal [NI];
`ifdef CORR_PEAK2_EN
    logic [15:0]   sec [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : gInst
        corr_search_ctrl #(
            .COORD_W (13),
            .CORR_W  (16),
            .X_MIN   (cfgXMin(g)),
            .X_MAX   (cfgXMax(g)),
            .Y_MIN   (0),
            .Y_MAX   (cfgYMax(g)),
            .STEP    (cfgStep(g)),
            .MODE_MIN(cfgMode(g))
        ) u_dut (
            .iCLK       (clk),
            .iRST_N     (rstN),
            .iStart     (start[g]),
            .iAbort     (abort[g]),
            .oX         (ox[g]),
            .oY         (oy[g]),
            .oCorrStart (cs[g]),
            .iCorrDone  (mdlDone[g] | spur[g]),
            .iCorrVal   (mdlVal[g]),
            .oBusy      (busy[g]),
            .oDone      (dn[g]),
            .oBestX     (bx[g]),
            .oBestY     (by[g]),
            .oBestCorr  (bc[g]),
            .oBestValid (bv[g])
`ifdef CORR_PEAK2_EN
            ,
            .oSecondCorr(sec[g])
`endif
        );
    end

    int nChecks = 0;
    int nPass   = 0;
    coord_t coordQ[$];
    res_t   resQ[$];
    int pulseCnt [NI];
    int doneCnt  [NI];
    int scoreSel [NI];
    int lat      [NI];
    logic [12:0] capX [NI];
    logic [12:0] capY [NI];

    task automatic chk(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic failNote(input string name, input int inst);
        nChecks++;
        $display("FAIL %s: unexpected event on instance %0d (t=%0t)", name, inst, $time);
    endtask

    function automatic logic [15:0] score(input int sel, input logic [12:0] x, input logic [12:0] y);
        case (sel)
            0:       return 16'(10 * int'(y) + int'(x));
            1:       return (x == 13'd2 && y == 13'd1) ? 16'd7 : 16'd50;
            default: return 16'd5;
        endcase
    endfunction

    // Correlator model: answers each oCorrStart with a one-cycle done three cycles later.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            mdlDone[i] = 1'b0;
            if (!rstN) begin
                lat[i] = 0;
            end else begin
                if (lat[i] > 0) begin
                    lat[i] = lat[i] - 1;
                    if (lat[i] == 0) begin
                        mdlDone[i] = 1'b1;
                        mdlVal[i]  = score(scoreSel[i], capX[i], capY[i]);
                    end
                end
                if (cs[i]) begin
                    lat[i]  = 3;
                    capX[i] = ox[i];
                    capY[i] = oy[i];
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a start pulse or a done pulse.
    coord_t mc;
    res_t   mr;
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rstN && cs[i]) begin
                pulseCnt[i]++;
                if (coordQ.size() == 0) begin
                    failNote("start_pulse", i);
                end else begin
                    mc = coordQ.pop_front();
                    chk("start_inst", i, mc.inst);
                    chk("start_x", ox[i], mc.x);
                    chk("start_y", oy[i], mc.y);
                end
            end
            if (rstN && dn[i]) begin
                doneCnt[i]++;
                if (resQ.size() == 0) begin
                    failNote("done_pulse", i);
                end else begin
                    mr = resQ.pop_front();
                    chk("done_inst", i, mr.inst);
                    chk("best_x", bx[i], mr.x);
                    chk("best_y", by[i], mr.y);
                    chk("best_corr", bc[i], mr.corr);
                    chk("best_valid_at_done", bv[i], 1);
                    chk("busy_at_done", busy[i], 1);
`ifdef CORR_PEAK2_EN
                    chk("second_corr", sec[i], mr.sec);
`endif
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pushScan(input int i, input int maxN);
        int n;
        coord_t c;
        n = 0;
        for (int y = 0; y <= int'(cfgYMax(i)); y += int'(cfgStep(i))) begin
            for (int x = int'(cfgXMin(i)); x <= int'(cfgXMax(i)); x += int'(cfgStep(i))) begin
                if (n < maxN) begin
                    c.inst = i; c.x = x; c.y = y;
                    coordQ.push_back(c);
                end
                n++;
            end
        end
    endtask

    task automatic startPulse(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        chk("busy_after_start", busy[i], 1);
        chk("corrstart_t1", cs[i], 1);
        chk("valid_cleared_on_start", bv[i], 0);
        tick();
        chk("corrstart_t2", cs[i], 0);
        chk("busy_t2", busy[i], 1);
    endtask

    task automatic beginScan(input int i, input int sel, input int ex, input int ey,
                             input int ec, input int es, output int base);
        res_t r;
        scoreSel[i] = sel;
        pushScan(i, 1000);
        r.inst = i; r.x = ex; r.y = ey; r.corr = ec; r.sec = es;
        resQ.push_back(r);
        base = pulseCnt[i];
        startPulse(i);
    endtask

    task automatic finishScan(input int i, input int n, input int base);
        int k;
        k = 0;
        while (!dn[i] && k < 400) begin
            tick();
            k++;
        end
        chk("done_seen", dn[i], 1);
        tick();
        chk("done_one_cycle", dn[i], 0);
        chk("busy_after_done", busy[i], 0);
        chk("valid_after_done", bv[i], 1);
        repeat (3) tick();
        chk("valid_held", bv[i], 1);
        chk("pulse_count", pulseCnt[i] - base, n);
        chk("coord_queue_drained", coordQ.size(), 0);
        chk("result_queue_drained", resQ.size(), 0);
    endtask

    task automatic runScan(input int i, input int sel, input int n, input int ex,
                           input int ey, input int ec, input int es);
        int base;
        beginScan(i, sel, ex, ey, ec, es, base);
        finishScan(i, n, base);
    endtask

    initial begin
        int base;
        int seen;
        int k;
        start = '0; abort = '0; spur = '0; rstN = 1'b0;
        for (int i = 0; i < NI; i++) begin
            scoreSel[i] = 0; pulseCnt[i] = 0; doneCnt[i] = 0;
            lat[i] = 0; mdlVal[i] = '0; capX[i] = '0; capY[i] = '0;
        end
        repeat (3) tick();
        chk("rst_x", ox[0], 0);
        chk("rst_y", oy[0], 0);
        chk("rst_x_inst3", ox[3], 8189);
        chk("rst_corrstart", cs[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_valid", bv[0], 0);
        chk("rst_best_x", bx[0], 0);
        chk("rst_best_y", by[0], 0);
        chk("rst_best_corr", bc[0], 0);
        rstN = 1'b1;
        tick();

        runScan(0, 0, 12, 3, 2, 23, 22);
        runScan(1, 1, 12, 2, 1, 7, 50);
        runScan(0, 2, 12, 0, 0, 5, 5);
        runScan(2, 0, 9, 4, 4, 44, 42);
        runScan(3, 0, 4, 8191, 2, 8211, 8209);

        // Abort during the fifth WAIT.
        scoreSel[0] = 0;
        pushScan(0, 5);
        startPulse(0);
        seen = 1; k = 0;
        while (seen < 5 && k < 200) begin
            tick();
            k++;
            if (cs[0]) seen++;
        end
        chk("abort_reached_5th_start", seen, 5);
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort_busy", busy[0], 0);
        chk("abort_valid", bv[0], 0);
        chk("abort_best_corr", bc[0], 0);
        chk("abort_best_x", bx[0], 0);
        chk("abort_no_done", dn[0], 0);
        base = doneCnt[0];
        repeat (8) tick();
        chk("abort_done_count", doneCnt[0], base);
        chk("abort_queue_drained", coordQ.size(), 0);
        runScan(0, 0, 12, 3, 2, 23, 22);

        // Asynchronous reset mid-scan.
        pushScan(0, 3);
        startPulse(0);
        seen = 1; k = 0;
        while (seen < 3 && k < 200) begin
            tick();
            k++;
            if (cs[0]) seen++;
        end
        tick();
        chk("pre_reset_x", ox[0], 2);
        rstN = 1'b0;
        #1;
        chk("mid_rst_x", ox[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_corrstart", cs[0], 0);
        chk("mid_rst_best_corr", bc[0], 0);
        chk("mid_rst_valid", bv[0], 0);
        repeat (2) tick();
        rstN = 1'b1;
        tick();

        // Spurious done in IDLE, then a scan with an extra start while busy.
        spur[0] = 1'b1;
        tick();
        spur[0] = 1'b0;
        tick();
        chk("spurious_busy", busy[0], 0);
        chk("spurious_best_corr", bc[0], 0);
        beginScan(0, 0, 3, 2, 23, 22, base);
        repeat (4) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        finishScan(0, 12, base);

        // Start and abort together in IDLE: abort wins.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("start_abort_busy", busy[0], 0);
        chk("start_abort_valid", bv[0], 0);
        chk("start_abort_corrstart", cs[0], 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
